// File: rtl/exe_stage.sv
// ============================================================================
// exe_stage
//   Execute stage of the five-stage pipeline. Decodes the ID/EX bundle,
//   forwards operands, runs the ALU, resolves beq/j and raises hazard stalls.
//   Results go into a registered EX/MEM bundle.
//
//   Build option:
//     EXE_FORWARD_EN  defined   -> EX/MEM and MEM/WB forwarding muxes.
//                                  Only load-use stalls.
//                     undefined -> operands are raw qa/qb. Decode stalls while
//                                  any older in-flight writer matches a source.
//
//   Ports:
//     clk, clr              clock, async active-high reset
//     in[163:0]             ID/EX bundle
//     id_rs, id_rt,         sources of the instruction currently in ID
//     id_use_rt
//     wb_regwrite, wb_dest, MEM/WB write-back port
//     wb_data
//     out[71:0]             registered EX/MEM bundle
//     stall                 hold PC and IF/ID, squash ID/EX data
//     flush                 clear IF/ID, squash ID/EX control
//     pc_redirect,          take pc_target as the next PC
//     pc_target
// ============================================================================
module exe_stage (
    input  logic         clk,
    input  logic         clr,
    input  logic [163:0] in,
    input  logic [4:0]   id_rs,
    input  logic [4:0]   id_rt,
    input  logic         id_use_rt,
    input  logic         wb_regwrite,
    input  logic [4:0]   wb_dest,
    input  logic [31:0]  wb_data,
    output logic [71:0]  out,
    output logic         stall,
    output logic         flush,
    output logic         pc_redirect,
    output logic [31:0]  pc_target
);

    // ---------------- ID/EX field extraction ----------------
    logic        w_regwrite, w_memtoreg, w_memwrite, w_beq, w_jump, w_alusrc, w_regdst;
    logic [2:0]  w_aluc;
    logic [4:0]  w_rt, w_rd, w_rs;
    logic [15:0] w_imm;
    logic [31:0] w_qa, w_qb, w_pc4;
    logic [25:0] w_adr;
    logic        w_ld;

    assign w_regwrite = in[0];
    assign w_memtoreg = in[1];
    assign w_memwrite = in[2];
    assign w_beq      = in[3];
    assign w_jump     = in[4];
    assign w_alusrc   = in[5];
    assign w_regdst   = in[6];
    assign w_aluc     = in[9:7];
    assign w_rt       = in[14:10];
    assign w_rd       = in[19:15];
    assign w_imm      = in[35:20];
    assign w_qa       = in[67:36];
    assign w_qb       = in[99:68];
    assign w_pc4      = in[131:100];
    assign w_adr      = in[157:132];
    assign w_rs       = in[162:158];
    assign w_ld       = in[163];

    logic [4:0]  w_dest;
    logic [31:0] w_sext;

    assign w_dest = w_regdst ? w_rd : w_rt;
    assign w_sext = {{16{w_imm[15]}}, w_imm};

    // ---------------- EX/MEM register fields ----------------
    logic [71:0] r_out;
    logic        w_m_regwrite, w_m_memtoreg;
    logic [4:0]  w_m_dest;
    logic [31:0] w_m_alu;

    assign w_m_regwrite = r_out[0];
    assign w_m_memtoreg = r_out[1];
    assign w_m_dest     = r_out[7:3];
    assign w_m_alu      = r_out[39:8];

    // ---------------- operand selection / hazard ----------------
    logic [31:0] w_fa, w_fb;
    logic        w_hazard;

`ifdef EXE_FORWARD_EN
    // EX/MEM beats MEM/WB because it is the younger write. A load in EX/MEM
    // has no data yet; that case is covered by the load-use stall instead.
    always_comb begin
        w_fa = w_qa;
        if (w_rs != 5'd0 && w_m_regwrite && !w_m_memtoreg && w_m_dest == w_rs)
            w_fa = w_m_alu;
        else if (w_rs != 5'd0 && wb_regwrite && wb_dest == w_rs)
            w_fa = wb_data;
    end

    always_comb begin
        w_fb = w_qb;
        if (w_rt != 5'd0 && w_m_regwrite && !w_m_memtoreg && w_m_dest == w_rt)
            w_fb = w_m_alu;
        else if (w_rt != 5'd0 && wb_regwrite && wb_dest == w_rt)
            w_fb = wb_data;
    end

    assign w_hazard = w_ld && w_regwrite && (w_dest != 5'd0) &&
                      ((w_dest == id_rs) || (id_use_rt && (w_dest == id_rt)));
`else
    assign w_fa = w_qa;
    assign w_fb = w_qb;

    // Without forwarding, ID must wait until no older writer (EX, EX/MEM or
    // MEM/WB) targets one of its sources; the stall re-evaluates every cycle.
    function automatic logic busy(input logic [4:0] src);
        busy = (src != 5'd0) &&
               ((w_regwrite   && w_dest   == src) ||
                (w_m_regwrite && w_m_dest == src) ||
                (wb_regwrite  && wb_dest  == src));
    endfunction

    assign w_hazard = busy(id_rs) || (id_use_rt && busy(id_rt));

    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{w_ld, w_rs, wb_data, w_m_memtoreg, w_m_alu};
`endif

    // ---------------- ALU ----------------
    logic [31:0] w_op2, w_alu;

    assign w_op2 = w_alusrc ? w_sext : w_fb;

    always_comb begin
        w_alu = 32'd0;
        case (w_aluc)
            3'b000: w_alu = w_fa + w_op2;
            3'b001: w_alu = w_fa - w_op2;
            3'b010: w_alu = w_fa & w_op2;
            3'b011: w_alu = w_fa | w_op2;
            3'b100: w_alu = w_fa ^ w_op2;
            3'b101: w_alu = {31'd0, $signed(w_fa) < $signed(w_op2)};
            3'b110: w_alu = w_fb << w_imm[10:6];
            3'b111: w_alu = {w_imm, 16'd0};
            default: w_alu = 32'd0;
        endcase
    end

    // ---------------- branch / jump resolution ----------------
    logic        w_taken;
    logic [31:0] w_btarget, w_jtarget;

    assign w_taken   = w_beq && (w_fa == w_fb);
    assign w_btarget = w_pc4 + {w_sext[29:0], 2'b00};
    assign w_jtarget = {w_pc4[31:28], w_adr, 2'b00};

    assign pc_redirect = w_taken || w_jump;
    assign flush       = pc_redirect;
    assign pc_target   = w_jump ? w_jtarget : w_btarget;
    // The stalled ID instruction is being squashed anyway on a redirect.
    assign stall       = w_hazard && !flush;

    // ---------------- EX/MEM register ----------------
    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_out <= 72'd0;
        else
            r_out <= {w_fb, w_alu, w_dest, w_memwrite, w_memtoreg, w_regwrite};
    end

    assign out = r_out;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;

    typedef struct packed {
        logic        ld;
        logic [4:0]  rs;
        logic [25:0] adr;
        logic [31:0] pc4;
        logic [31:0] qb;
        logic [31:0] qa;
        logic [15:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [2:0]  aluc;
        logic        regdst, alusrc, jump, beq, memwr, memtoreg, regwr;
    } idex_t;

    typedef struct packed {
        logic [31:0] store;
        logic [31:0] alu;
        logic [4:0]  dest;
        logic        memwr, memtoreg, regwr;
    } exmem_t;

    logic        clk = 1'b0;
    logic        clr;
    idex_t       ib;
    logic [4:0]  id_rs, id_rt;
    logic        id_use_rt;
    logic        wb_regwrite;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic [71:0] out_w;
    logic        stall, flush, pc_redirect;
    logic [31:0] pc_target;

    exmem_t exp_out;
    int     ncmp = 0;
    int     nfail = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .clr(clr), .in(ib),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rt(id_use_rt),
        .wb_regwrite(wb_regwrite), .wb_dest(wb_dest), .wb_data(wb_data),
        .out(out_w), .stall(stall), .flush(flush),
        .pc_redirect(pc_redirect), .pc_target(pc_target)
    );

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Operand value the instruction should see: newest in-flight write wins.
    function automatic logic [31:0] opnd(input logic [4:0] src, input logic [31:0] raw);
`ifdef EXE_FORWARD_EN
        if (src != 0 && exp_out.regwr && !exp_out.memtoreg && exp_out.dest == src)
            return exp_out.alu;
        if (src != 0 && wb_regwrite && wb_dest == src)
            return wb_data;
`endif
        return raw;
    endfunction

    function automatic bit pending(input logic [4:0] src, input logic [4:0] d);
        return src != 0 && ((ib.regwr && d == src) ||
                            (exp_out.regwr && exp_out.dest == src) ||
                            (wb_regwrite && wb_dest == src));
    endfunction

    task automatic model(output exmem_t n, output bit st, output bit fl, output bit rd,
                         output logic [31:0] tg);
        logic [31:0] a, b, sx, op2, r;
        logic [4:0]  d;
        bit          hz;
        a   = opnd(ib.rs, ib.qa);
        b   = opnd(ib.rt, ib.qb);
        sx  = 32'($signed(ib.imm));
        op2 = ib.alusrc ? sx : b;
        d   = ib.regdst ? ib.rd : ib.rt;
        case (ib.aluc)
            3'd0: r = a + op2;
            3'd1: r = a - op2;
            3'd2: r = a & op2;
            3'd3: r = a | op2;
            3'd4: r = a ^ op2;
            3'd5: r = ($signed(a) < $signed(op2)) ? 32'd1 : 32'd0;
            3'd6: r = b << ib.imm[10:6];
            default: r = {ib.imm, 16'h0000};
        endcase
        n  = '{store: b, alu: r, dest: d, memwr: ib.memwr, memtoreg: ib.memtoreg, regwr: ib.regwr};
        rd = (ib.beq && a == b) || ib.jump;
        fl = rd;
        tg = ib.jump ? {ib.pc4[31:28], ib.adr, 2'b00} : ib.pc4 + sx * 32'd4;
`ifdef EXE_FORWARD_EN
        hz = ib.ld && ib.regwr && d != 0 && (d == id_rs || (id_use_rt && d == id_rt));
`else
        hz = pending(id_rs, d) || (id_use_rt && pending(id_rt, d));
`endif
        st = hz && !fl;
    endtask

    // One clock: check combinational outputs mid-cycle, then the register.
    task automatic cyc(input string tag);
        exmem_t n;
        bit st, fl, rd;
        logic [31:0] tg;
        @(negedge clk);
        model(n, st, fl, rd, tg);
        chk({tag, ".stall"}, 72'(stall), 72'(st));
        chk({tag, ".flush"}, 72'(flush), 72'(fl));
        chk({tag, ".redir"}, 72'(pc_redirect), 72'(rd));
        if (rd) chk({tag, ".target"}, 72'(pc_target), 72'(tg));
        if (clr) n = '0;
        @(posedge clk);
        #1;
        exp_out = n;
        chk({tag, ".out"}, out_w, exp_out);
    endtask

    task automatic quiet();
        ib = '0; id_rs = 0; id_rt = 0; id_use_rt = 0;
        wb_regwrite = 0; wb_dest = 0; wb_data = 0;
    endtask

    initial begin
        logic [191:0] rnd;
        clr = 1'b1;
        quiet();
        exp_out = '0;

        // ---- reset: bundle present while clr held, then released ----
        rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        ib = rnd[163:0];
        ib.beq = 0; ib.jump = 0; ib.regwr = 1; ib.regdst = 1; ib.rd = 5'd5;
        cyc("rst_hold");
        chk("rst_hold.zero", out_w, 72'd0);
        clr = 1'b0;
        cyc("rst_release");

        // ---- asynchronous clear mid-operation ----
        @(negedge clk);
        clr = 1'b1;
        #1;
        exp_out = '0;
        chk("async_clr", out_w, 72'd0);
        #1 clr = 1'b0;
        #1 chk("async_clr.hold", out_w, 72'd0);
        quiet();
        cyc("post_clr");

        // ---- ALU directed ----
        ib.qa = 7; ib.qb = 5; ib.aluc = 3'd1; ib.regdst = 1; ib.rd = 3; ib.regwr = 1;
        cyc("sub");
        chk("sub.result", 72'(out_w[39:8]), 72'd2);
        chk("sub.dest", 72'(out_w[7:3]), 72'd3);
        quiet();
        ib.qa = 32'hFFFF_FFFF; ib.qb = 0; ib.aluc = 3'd5;
        cyc("slt");
        chk("slt.result", 72'(out_w[39:8]), 72'd1);
        quiet();
        ib.imm = 16'h1234; ib.aluc = 3'd7;
        cyc("lui");
        chk("lui.result", 72'(out_w[39:8]), 72'h1234_0000);

        // ---- forwarding ----
        quiet();
        ib.regwr = 1; ib.regdst = 1; ib.rd = 4; ib.qa = 100;
        cyc("fw_prod");
        quiet();
        ib.rs = 4; ib.alusrc = 1; ib.imm = 1;
        wb_regwrite = 1; wb_dest = 4; wb_data = 50;
        cyc("fw_exmem");
`ifdef EXE_FORWARD_EN
        chk("fw_exmem.result", 72'(out_w[39:8]), 72'd101);
`endif
        cyc("fw_wb");
`ifdef EXE_FORWARD_EN
        chk("fw_wb.result", 72'(out_w[39:8]), 72'd51);
`endif
        ib.rs = 0; ib.qa = 3; wb_dest = 0;
        cyc("fw_r0");
        chk("fw_r0.result", 72'(out_w[39:8]), 72'd4);

        // ---- branch ----
        quiet();
        cyc("br_idle");
        ib.beq = 1; ib.qa = 9; ib.qb = 9; ib.pc4 = 32'h100; ib.imm = 16'hFFFF;
        #1;
        chk("br.redir", 72'(pc_redirect), 72'd1);
        chk("br.flush", 72'(flush), 72'd1);
        chk("br.target", 72'(pc_target), 72'hFC);
        cyc("br_taken");
        ib.qb = 8;
        #1;
        chk("br_nt.redir", 72'(pc_redirect), 72'd0);
        chk("br_nt.flush", 72'(flush), 72'd0);
        cyc("br_not");

        // ---- jump overrides a simultaneous load-use ----
        quiet();
        ib.jump = 1; ib.pc4 = 32'hA000_0004; ib.adr = 26'h10;
        ib.ld = 1; ib.regwr = 1; ib.rt = 8; id_rs = 8;
        #1;
        chk("jmp.target", 72'(pc_target), 72'hA000_0040);
        chk("jmp.flush", 72'(flush), 72'd1);
        chk("jmp.stall", 72'(stall), 72'd0);
        cyc("jmp");
        quiet();
        cyc("jmp_drain");

        // ---- load-use ----
        ib.ld = 1; ib.regwr = 1; ib.rt = 8; id_rs = 8;
        #1 chk("lu.stall1", 72'(stall), 72'd1);
        cyc("lu_load");
        ib = '0;
        #1;
`ifdef EXE_FORWARD_EN
        chk("lu.stall2", 72'(stall), 72'd0);
`else
        chk("lu.stall2", 72'(stall), 72'd1);
`endif
        cyc("lu_bubble");
        quiet();
        cyc("lu_drain");

        // ---- ALU producer: no stall with forwarding, 3 cycles without ----
        ib.regwr = 1; ib.regdst = 1; ib.rd = 8; id_rs = 8;
        #1 chk("raw.ex", 72'(stall), 72'(`ifdef EXE_FORWARD_EN 0 `else 1 `endif));
        cyc("raw_ex");
        ib = '0;
        #1 chk("raw.mem", 72'(stall), 72'(`ifdef EXE_FORWARD_EN 0 `else 1 `endif));
        cyc("raw_mem");
        wb_regwrite = 1; wb_dest = 8; wb_data = 32'h55;
        #1 chk("raw.wb", 72'(stall), 72'(`ifdef EXE_FORWARD_EN 0 `else 1 `endif));
        cyc("raw_wb");
        wb_regwrite = 0;
        #1 chk("raw.done", 72'(stall), 72'd0);
        cyc("raw_done");

        // ---- randomized ----
        for (int i = 0; i < 400; i++) begin
            rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            ib = rnd[163:0];
            ib.rs = 5'($urandom_range(0, 7));
            ib.rt = 5'($urandom_range(0, 7));
            ib.rd = 5'($urandom_range(0, 7));
            ib.beq = ($urandom_range(0, 3) == 0);
            ib.jump = ($urandom_range(0, 7) == 0);
            ib.ld = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) ib.qb = ib.qa;
            if ($urandom_range(0, 7) == 0) ib = '0;
            id_rs = 5'($urandom_range(0, 7));
            id_rt = 5'($urandom_range(0, 7));
            id_use_rt = 1'($urandom_range(0, 1));
            wb_regwrite = 1'($urandom_range(0, 1));
            wb_dest = 5'($urandom_range(0, 7));
            wb_data = $urandom();
            if ($urandom_range(0, 31) == 0) begin
                clr = 1'b1;
                #1 exp_out = '0;
            end
            cyc("rand");
            clr = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
